// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package serial_subtractor_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done handshake and operand/result bus for the serial subtractor.
// The master drives the request; the slave (the subtractor) returns the result.
interface serial_subtractor_if
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, ovf
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, ovf
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor built as two half-subtractors plus an OR,
// mirroring the composition of the full adder.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  logic w_d1;
  logic w_b1;
  logic w_b2;

  // first half-subtractor: x - y
  assign w_d1 = x ^ y;
  assign w_b1 = ~x & y;

  // second half-subtractor: (x - y) - bin
  assign d    = w_d1 ^ bin;
  assign w_b2 = ~w_d1 & bin;

  assign bout = w_b1 | w_b2;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - bin, one bit per
// clock LSB first, through a single full-subtractor cell and a borrow flop.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sa;
  logic [WIDTH-1:0]   r_sb;
  logic [WIDTH-1:0]   r_res;
  logic               r_brw;
  logic               r_amsb;
  logic               r_bmsb;
  logic               r_ovf;
  logic               r_busy;
  logic               r_done;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_d;
  logic               w_bo;
  logic               w_last;

  assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

  full_subtractor u_fs (
    .x    (r_sa[0]),
    .y    (r_sb[0]),
    .bin  (r_brw),
    .d    (w_d),
    .bout (w_bo)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (bus.start) w_state_nxt = ST_RUN;
      ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
      ST_DONE:                w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // busy/done are decoded from the next state so they leave a flop directly
  always_comb begin
    w_busy_nxt = (w_state_nxt == ST_RUN);
    w_done_nxt = (w_state_nxt == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_sa   <= '0;
      r_sb   <= '0;
      r_res  <= '0;
      r_brw  <= 1'b0;
      r_amsb <= 1'b0;
      r_bmsb <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_sa   <= bus.a;
            r_sb   <= bus.b;
            r_brw  <= bus.bin;
            r_cnt  <= '0;
            r_amsb <= bus.a[WIDTH-1];
            r_bmsb <= bus.b[WIDTH-1];
          end
        end
        ST_RUN: begin
          r_res <= {w_d, r_res[WIDTH-1:1]};
          r_sa  <= {1'b0, r_sa[WIDTH-1:1]};
          r_sb  <= {1'b0, r_sb[WIDTH-1:1]};
          r_brw <= w_bo;
          if (!w_last) begin
            r_cnt <= r_cnt + CNT_W'(1);
          end else begin
            // the bit entering now becomes the result MSB
            r_ovf <= (r_amsb != r_bmsb) & (w_d != r_amsb);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.diff = r_res;
  assign bus.bout = r_brw;
  assign bus.ovf  = r_ovf;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH=8), with
// hand-computed expected results and cycle-exact handshake checks.
module tb_serial_subtractor;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  serial_subtractor_if #(.WIDTH(W)) bus ();

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // inj: 0 = plain op, 1 = extra start 3 cycles into RUN, 2 = reset 4 cycles into RUN
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin,
                        input logic [W-1:0] ed, input logic ebo, input logic eovf,
                        input int inj);
    bus.a = a; bus.b = b; bus.bin = bin; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    chk("accept_busy", 32'(bus.busy), 32'd1);
    chk("accept_done", 32'(bus.done), 32'd0);
    for (int k = 1; k <= W; k++) begin
      if (inj == 1 && k == 3) begin
        bus.start = 1'b1; bus.a = 8'hAA; bus.b = 8'h11; bus.bin = 1'b1;
      end
      if (inj == 2 && k == 4) begin
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rst_mid_busy", 32'(bus.busy), 32'd0);
        chk("rst_mid_done", 32'(bus.done), 32'd0);
        chk("rst_mid_diff", 32'(bus.diff), 32'd0);
        chk("rst_mid_bout", 32'(bus.bout), 32'd0);
        for (int j = 0; j < W + 2; j++) begin
          @(posedge clk); #1;
          chk("rst_no_done", 32'(bus.done), 32'd0);
        end
        return;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (k < W) begin
        chk("run_busy", 32'(bus.busy), 32'd1);
        chk("run_done", 32'(bus.done), 32'd0);
      end else begin
        chk("done_pulse", 32'(bus.done), 32'd1);
        chk("done_busy",  32'(bus.busy), 32'd0);
        chk("diff",       32'(bus.diff), 32'(ed));
        chk("bout",       32'(bus.bout), 32'(ebo));
        chk("ovf",        32'(bus.ovf),  32'(eovf));
      end
    end
    @(posedge clk); #1;
    chk("idle_done", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
    chk("hold_diff", 32'(bus.diff), 32'(ed));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.start = 1'b1;
    bus.a = 8'h12; bus.b = 8'h34; bus.bin = 1'b0;
    // reset held together with start: reset must win
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_diff", 32'(bus.diff), 32'd0);
    chk("rst_bout", 32'(bus.bout), 32'd0);
    chk("rst_ovf",  32'(bus.ovf),  32'd0);
    bus.start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_rst", 32'(bus.busy), 32'd0);

    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 0);
    run_op(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 0);
    run_op(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, 0);
    run_op(8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1, 0);
    run_op(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 0);
    run_op(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1);
    run_op(8'h33, 8'h11, 1'b0, 8'h22, 1'b0, 1'b0, 2);
    run_op(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
